// File: rtl/fifo_rw_ctrl_pkg.sv
// Shared sizing constants for the FIFO read/write controller and its storage.
package fifo_rw_ctrl_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/fifo_rw_ctrl_dualport_rw.sv
// Dual-port storage: independent write and read ports, registered read data.
module dualport_rw
  import fifo_rw_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] data_out
);
  localparam int ENTRIES = 2 ** ADDR_W;

  logic [ENTRIES-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]              dout_q, dout_d;

  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
    if (write_en) mem_d[write_address] = data_in;
    if (read_en)  dout_d = mem_q[read_address];
  end

  // Array contents are left alone on reset; only the read register clears.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign data_out = dout_q;
endmodule

// File: rtl/fifo_rw_ctrl.sv
// FIFO controller: pointers, occupancy count, flags and error pulses around dualport_rw.
module fifo_rw_ctrl
  import fifo_rw_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err
);
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(2 ** ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d, wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic              push, pop;

  assign full  = (count_q == CAP);
  assign empty = (count_q == '0);

  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    valid_d  = pop;
    wr_err_d = wr_en && full;
    rd_err_d = rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Reset gates both ports so a concurrent request never touches storage.
  dualport_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk          (clk),
    .rst          (rst),
    .write_en     (push && !rst),
    .write_address(wr_ptr_q),
    .data_in      (data_in),
    .read_en      (pop && !rst),
    .read_address (rd_ptr_q),
    .data_out     (data_out)
  );

  assign data_valid = valid_q;
  assign count      = count_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;
endmodule

// File: tb/tb_fifo_rw_ctrl.sv
// Directed bench for fifo_rw_ctrl: queue-based reference model plus literal checkpoints.
module tb_fifo_rw_ctrl;
  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [3:0] data_in, data_out;
  logic       data_valid, full, empty, wr_err, rd_err;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_rw_ctrl #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  // Reference model: a plain queue holding at most 4 entries.
  logic [3:0] q[$];
  logic [3:0] m_dout;
  logic       m_dv, m_werr, m_rerr, m_ready;
  initial m_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dout = 4'h0; m_dv = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
      m_ready = 1'b1;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == 4);
      was_empty = (q.size() == 0);
      m_werr = wr_en && was_full;
      m_rerr = rd_en && was_empty;
      m_dv   = rd_en && !was_empty;
      if (m_dv) m_dout = q.pop_front();
      if (wr_en && !was_full) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      chk("count",      int'(count),      q.size());
      chk("full",       int'(full),       int'(q.size() == 4));
      chk("empty",      int'(empty),      int'(q.size() == 0));
      chk("data_valid", int'(data_valid), int'(m_dv));
      chk("data_out",   int'(data_out),   int'(m_dout));
      chk("wr_err",     int'(wr_err),     int'(m_werr));
      chk("rd_err",     int'(rd_err),     int'(m_rerr));
    end
  end

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [3:0] d, input logic r, input logic rs);
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_pop[6];
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 4'h9;

    step(1, 4'h9, 1, 1);
    step(1, 4'h9, 1, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_dv",    int'(data_valid), 0);
    chk("rst_dout",  int'(data_out), 0);

    step(1, 4'h4, 0, 0);
    step(1, 4'h8, 0, 0);
    step(1, 4'hF, 0, 0);
    step(1, 4'hE, 0, 0);
    chk("fill_full",  int'(full),  1);
    chk("fill_count", int'(count), 4);

    step(1, 4'h3, 0, 0);
    chk("ovf_wr_err", int'(wr_err), 1);
    chk("ovf_count",  int'(count),  4);
    step(0, 4'h0, 0, 0);
    chk("ovf_pulse",  int'(wr_err), 0);

    step(0, 4'h0, 1, 0); chk("pop0", int'(data_out), 4'h4); chk("pop0_dv", int'(data_valid), 1);
    step(0, 4'h0, 1, 0); chk("pop1", int'(data_out), 4'h8);
    step(0, 4'h0, 1, 0); chk("pop2", int'(data_out), 4'hF);
    step(0, 4'h0, 1, 0); chk("pop3", int'(data_out), 4'hE);
    step(0, 4'h0, 0, 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_dv",    int'(data_valid), 0);
    chk("drain_hold",  int'(data_out), 4'hE);

    step(1, 4'h7, 1, 0);
    chk("unf_rd_err", int'(rd_err), 1);
    chk("unf_dv",     int'(data_valid), 0);
    chk("unf_count",  int'(count), 1);
    step(0, 4'h0, 1, 0);
    chk("unf_pop7",   int'(data_out), 4'h7);

    // Pointers now sit at 1; six paired operations push them past 3.
    step(1, 4'hA, 0, 0);
    step(1, 4'hB, 0, 0);
    exp_pop = '{4'hA, 4'hB, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 1; i <= 6; i++) begin
      step(1, 4'(i), 1, 0);
      chk("wrap_data",  int'(data_out), int'(exp_pop[i-1]));
      chk("wrap_count", int'(count), 2);
    end

    step(1, 4'hC, 0, 0);
    chk("pre_rst_count", int'(count), 3);
    step(0, 4'h0, 1, 1);
    chk("mid_rst_dv",    int'(data_valid), 0);
    chk("mid_rst_count", int'(count), 0);
    step(1, 4'h9, 1, 0);
    chk("post_rst_rd_err", int'(rd_err), 1);
    step(0, 4'h0, 1, 0);
    chk("post_rst_data", int'(data_out), 4'h9);
    step(0, 4'h0, 1, 0);
    chk("post_rst_empty_err", int'(rd_err), 1);

    // Short mixed burst checked against the model only.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);

    step(0, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_rw_ctrl.md
FIFO_RW_CTRL -- requirements
Module: fifo_rw_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the data width.
REQ-002 Parameter ADDR_W, default 2, SHALL set the pointer width; depth SHALL be 2**ADDR_W (4).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 wr_en  input  1  SHALL be the push request.
REQ-006 data_in  input  DATA_W  SHALL be the push data, sampled when a push is accepted.
REQ-007 rd_en  input  1  SHALL be the pop request.
REQ-008 data_out  output  DATA_W  SHALL be the registered pop data.
REQ-009 data_valid  output  1  SHALL mark data_out as holding freshly popped data.
REQ-010 full  output  1  SHALL be high when count equals depth.
REQ-011 empty  output  1  SHALL be high when count equals 0.
REQ-012 count  output  ADDR_W+1  SHALL be the number of stored entries, 0..depth.
REQ-013 wr_err  output  1  SHALL pulse for one cycle on a rejected push.
REQ-014 rd_err  output  1  SHALL pulse for one cycle on a rejected pop.

Function
REQ-015 Push accepted SHALL be wr_en && !full, evaluated on pre-edge state; accepted data written at wr_ptr, wr_ptr incremented.
REQ-016 Pop accepted SHALL be rd_en && !empty, evaluated on pre-edge state; entry at rd_ptr read, rd_ptr incremented.
REQ-017 Pointers SHALL be ADDR_W bits and wrap modulo depth (3 -> 0) without extra logic.
REQ-018 Read latency SHALL be one cycle: data_out and data_valid update on the edge that accepts the pop.
REQ-019 data_valid SHALL be low on any cycle following an edge with no accepted pop; data_out SHALL hold its last value.
REQ-020 count SHALL increment on push-only, decrement on pop-only, stay unchanged on simultaneous accepted push and pop.
REQ-021 When full, push SHALL be rejected even if a pop is accepted on the same edge; wr_err pulses.
REQ-022 When empty, pop SHALL be rejected even if a push is accepted on the same edge; rd_err pulses; pushed data is not bypassed.
REQ-023 full and empty SHALL be derived combinationally from registered count.
REQ-024 Storage SHALL be a dual-port array with independent write and read addresses; simultaneous write and read to the same address cannot occur through this controller.

Reset
REQ-025 On rst high at a rising edge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, wr_err=0, rd_err=0.
REQ-026 rst SHALL override any concurrent wr_en/rd_en; in-flight pops are discarded and no write occurs.
REQ-027 Storage contents need not be cleared; empty after reset makes them unobservable.

Structure
REQ-028 Shared package SHALL hold DATA_W, ADDR_W defaults and DEPTH constant.
REQ-029 Storage SHALL be one sub-module, dualport_rw, driven by clk, rst, write_en/write_address/data_in and read_en/read_address, with registered data_out; the controller SHALL contain pointer, count, flag and error logic only.

Verification
REQ-030 Reset: rst high 2 cycles with wr_en=rd_en=1 -> count=0, empty=1, full=0, data_valid=0, data_out=0.
REQ-031 Fill and drain: push 4,8,F,E -> full=1, count=4; pop 4 times -> data_out 4,8,F,E each one cycle after pop, data_valid=1, then empty=1.
REQ-032 Overflow: push 5th value 3 when full -> wr_err pulses 1 cycle, count stays 4, subsequent pops return no 3.
REQ-033 Underflow and simultaneous on empty: rd_en=1 with wr_en=1, data_in=7 on empty -> rd_err pulse, data_valid=0, count=1; next pop returns 7.
REQ-034 Wrap-around: 6 push/pop pairs of 1..6 at count=2 -> count stays 2, pointers wrap past 3, pops return data in push order.
REQ-035 Reset mid-operation: rst at count=3 during pop -> data_valid=0, count=0, next push/pop returns new data only.
